// File: rtl/ysyx_22050019_skid_reg.sv
// Two-entry registered pipeline stage (main + skid) with valid/ready on both sides.
// Latency: data pushed at edge N is on out_data with out_valid=1 after edge N.
// Backpressure: absorbs one extra beat on an output stall; in_ready is a pure flop, no path from out_ready.
module ysyx_22050019_skid_reg #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    // Encoding chosen so bit 0 is main_v and bit 1 is skid_v: both outputs come straight off flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          main_v;
    logic          skid_v;
    logic          push;
    logic          pop;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;

    assign main_v    = state_q[0];
    assign skid_v    = state_q[1];
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move us
                    if (pop) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= RESET_VAL;
        end else if (flush) begin
            main_q <= RESET_VAL;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end else if (load_main_in) begin
            main_q <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_skid_reg.sv
// Directed + random bench for the two-entry skid stage; queue-based scoreboard of accepted beats.
module tb_ysyx_22050019_skid_reg;

    localparam int DW = 32;
    localparam logic [DW-1:0] RST_VAL = '0;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_cmp;
    int n_err;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] last_main;

    ysyx_22050019_skid_reg #(.DW(DW), .RESET_VAL(RST_VAL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, DW'(out_valid), DW'(mq.size() > 0));
        check({tag, ".in_ready"},  DW'(in_ready),  DW'(mq.size() < 2));
        check({tag, ".out_data"},  out_data, (mq.size() > 0) ? mq[0] : last_main);
    endtask

    // Called just after a falling edge with inputs already driven; advances one cycle.
    task automatic step(input string tag);
        logic          push_e;
        logic          pop_e;
        logic [DW-1:0] exp_v;
        push_e = in_valid && (mq.size() < 2);
        pop_e  = out_ready && (mq.size() > 0);
        if (flush) begin
            mq.delete();
            last_main = RST_VAL;
        end else begin
            if (pop_e) begin
                exp_v = mq.pop_front();
                check({tag, ".pop_data"}, out_data, exp_v);
                if (mq.size() == 0) last_main = exp_v;
            end
            if (push_e) mq.push_back(in_data);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic          pend_v;
        logic [DW-1:0] pend_d;
        n_cmp     = 0;
        n_err     = 0;
        last_main = RST_VAL;
        rst_n     = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            @(posedge clk);
            @(negedge clk);
            check("rst.out_valid", DW'(out_valid), '0);
            check("rst.in_ready",  DW'(in_ready),  DW'(1));
            check("rst.out_data",  out_data, '0);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("post_rst");
        step("post_rst2");

        // Streaming
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            step("stream");
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step("stream_drain");
        step("stream_idle");

        // Backpressure
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step("bp_a");
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step("bp_b");
        check("bp.in_ready_low", DW'(in_ready), '0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC, 1'b0, 1'b0);
            step("bp_c_stall");
            check("bp.hold_a", out_data, 32'hA);
        end
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        step("bp_pop_a");
        check("bp.main_b", out_data, 32'hB);
        step("bp_push_c");
        drive(1'b0, '0, 1'b1, 1'b0);
        step("bp_pop_c");
        check("bp.empty", DW'(out_valid), '0);

        // Flush with simultaneous push while full
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        step("fl_fill1");
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        step("fl_fill2");
        drive(1'b1, 32'hF, 1'b1, 1'b1);
        step("flush");
        check("flush.out_valid", DW'(out_valid), '0);
        check("flush.in_ready",  DW'(in_ready),  DW'(1));
        check("flush.out_data",  out_data, RST_VAL);
        drive(1'b0, '0, 1'b1, 1'b0);
        step("post_flush");
        check("flush.no_f", DW'(out_valid), '0);

        // Asynchronous reset mid-operation
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        step("ar_fill1");
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        step("ar_fill2");
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", DW'(out_valid), '0);
        check("arst.in_ready",  DW'(in_ready),  DW'(1));
        check("arst.out_data",  out_data, RST_VAL);
        mq.delete();
        last_main = RST_VAL;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("arst_release");
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        step("arst_push");
        drive(1'b0, '0, 1'b1, 1'b0);
        step("arst_pop");

        // Random traffic; upstream holds a beat until it is accepted
        pend_v = 1'b0;
        pend_d = '0;
        for (int i = 0; i < 10000; i++) begin
            logic f;
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend_d = $urandom;
            end
            f = ($urandom_range(0, 31) == 0);
            drive(pend_v, pend_d, 1'($urandom_range(0, 2) != 0), f);
            if (pend_v && in_ready && !f) pend_v = 1'b0;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
